// File: rtl/level_pick.sv
// Lock-pick level controller: maps the pick position to a pin slot, tracks hold/opener attempts, reports done/fail.
// Latency 1 cycle for slot and all status outputs; there is no backpressure, every input is sampled each clock.
module level_pick #(
  parameter int NUM_SLOTS   = 16,
  parameter int Y_TOP       = 32,
  parameter int SLOT_H      = 28,
  parameter int X_LIMIT     = 500,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_TRIES   = 3,
  localparam int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] rand_in,
  input  logic          openner,
  input  logic [9:0]    pickY,
  input  logic [9:0]    pickLRx,
  output logic [SW-1:0] slot,
  output logic          slot_valid,
  output logic [SW-1:0] target,
  output logic          close,
  output logic          done,
  output logic          fail,
  output logic [3:0]    tries_left
);

  localparam int         Y_BOT    = Y_TOP + NUM_SLOTS * SLOT_H - 1;
  localparam int         CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [9:0] Y_TOP_W  = 10'(Y_TOP);
  localparam logic [9:0] SLOT_H_W = 10'(SLOT_H);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HOLD, S_DONE, S_FAIL} state_t;

  state_t        r_state;
  logic [SW-1:0] r_slot;
  logic          r_slot_valid;
  logic [SW-1:0] r_target;
  logic          r_close;
  logic          r_done;
  logic          r_fail;
  logic [3:0]    r_tries;
  logic [CW-1:0] r_hold;
  logic          r_open_q;

  logic          w_in_band;
  logic [SW-1:0] w_quot;
  logic [SW-1:0] w_slot_nxt;
  logic [SW-1:0] w_target_ld;
  logic [SW-1:0] w_target_nxt;
  logic          w_active;
  logic          w_on_tgt;
  logic          w_match;
  logic          w_attempt;
  logic          w_last_try;
  logic          w_hold_last;
  logic          w_go_fail;
  logic          w_go_done;
  logic          w_act_nxt;
  logic [SW-1:0] w_diff;
  logic          w_near;
  logic          w_close_nxt;

  assign w_in_band   = (int'(pickY) >= Y_TOP) && (int'(pickY) <= Y_BOT);
  assign w_quot      = SW'((pickY - Y_TOP_W) / SLOT_H_W);
  assign w_slot_nxt  = w_in_band ? w_quot : r_slot;
  assign w_target_ld = (int'(rand_in) > NUM_SLOTS - 1) ? SW'(NUM_SLOTS - 1) : rand_in;

  assign w_active    = (r_state == S_ARMED) || (r_state == S_HOLD);
  assign w_on_tgt    = r_slot_valid && (r_slot == r_target);
  assign w_match     = w_on_tgt && !openner && (int'(pickLRx) <= X_LIMIT);
  assign w_attempt   = w_active && openner && !r_open_q && !w_on_tgt;
  assign w_last_try  = (r_tries <= 4'd1);
  assign w_hold_last = (r_state == S_ARMED) ? (HOLD_CYCLES == 1)
                                            : (int'(r_hold) + 1 >= HOLD_CYCLES);
  assign w_go_fail   = w_active && start && w_attempt && w_last_try;
  assign w_go_done   = w_active && start && !w_attempt && w_match && w_hold_last;

  // close is registered against next-cycle slot/target/state so it lines up with the slot output
  assign w_act_nxt    = start && ((r_state == S_IDLE) || (w_active && !w_go_fail && !w_go_done));
  assign w_target_nxt = (r_state == S_IDLE && start) ? w_target_ld : r_target;
  assign w_diff       = (w_slot_nxt >= w_target_nxt) ? (w_slot_nxt - w_target_nxt)
                                                     : (w_target_nxt - w_slot_nxt);

  always_comb begin
    w_near = 1'b0;
    case (mode)
      2'd0:    w_near = (int'(w_diff) <= 2);
      2'd1:    w_near = (int'(w_diff) <= 1);
      default: w_near = 1'b0;
    endcase
  end

  assign w_close_nxt = w_act_nxt && w_in_band && (w_slot_nxt != w_target_nxt) && w_near;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_slot_valid <= 1'b0;
      r_target     <= '0;
      r_close      <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_tries      <= 4'd0;
      r_hold       <= '0;
      r_open_q     <= 1'b0;
    end else begin
      r_open_q     <= openner;
      r_slot_valid <= w_in_band;
      if (w_in_band) r_slot <= w_quot;
      r_close      <= w_close_nxt;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= w_target_ld;
            r_tries  <= 4'(MAX_TRIES);
            r_hold   <= '0;
            r_state  <= S_ARMED;
          end
        end
        S_ARMED, S_HOLD: begin
          if (!start) begin
            r_hold  <= '0;
            r_state <= S_IDLE;
          end else if (w_attempt) begin
            if (r_tries != 4'd0) r_tries <= r_tries - 4'd1;
            r_hold <= '0;
            if (w_last_try) begin
              r_fail  <= 1'b1;
              r_state <= S_FAIL;
            end else begin
              r_state <= S_ARMED;
            end
          end else if (w_match) begin
            if (w_hold_last) begin
              r_hold  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_hold  <= r_hold + 1'b1;
              r_state <= S_HOLD;
            end
          end else begin
            r_hold  <= '0;
            r_state <= S_ARMED;
          end
        end
        S_DONE: begin
          if (start) r_done  <= 1'b1;
          else       r_state <= S_IDLE;
        end
        S_FAIL: begin
          if (start) r_fail  <= 1'b1;
          else       r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign slot       = r_slot;
  assign slot_valid = r_slot_valid;
  assign target     = r_target;
  assign close      = r_close;
  assign done       = r_done;
  assign fail       = r_fail;
  assign tries_left = r_tries;

endmodule

// File: tb/tb_level_pick.sv
// Directed bench for level_pick at default parameters; hand-computed expectations, sampled on the falling edge.
module tb_level_pick;

  logic       Clk;
  logic       Reset_n;
  logic       start;
  logic [1:0] mode;
  logic [3:0] rand_in;
  logic       openner;
  logic [9:0] pickY;
  logic [9:0] pickLRx;
  logic [3:0] slot;
  logic       slot_valid;
  logic [3:0] target;
  logic       close;
  logic       done;
  logic       fail;
  logic [3:0] tries_left;

  int n_checks = 0;
  int n_fail   = 0;

  level_pick dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .mode(mode), .rand_in(rand_in),
    .openner(openner), .pickY(pickY), .pickLRx(pickLRx), .slot(slot),
    .slot_valid(slot_valid), .target(target), .close(close), .done(done),
    .fail(fail), .tries_left(tries_left)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b1; mode = 2'd2; rand_in = 4'd5;
    openner = 1'b0; pickY = 10'd185; pickLRx = 10'd400;

    // reset state
    @(negedge Clk);
    check_eq("rst_slot", slot, 0);
    check_eq("rst_valid", slot_valid, 0);
    check_eq("rst_target", target, 0);
    check_eq("rst_close", close, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fail", fail, 0);
    check_eq("rst_tries", tries_left, 0);

    // basic solve: slot 5 on first edge, done 4 cycles after match begins
    Reset_n = 1'b1;
    tick();
    check_eq("t1_slot", slot, 5);
    check_eq("t1_valid", slot_valid, 1);
    check_eq("t1_target", target, 5);
    check_eq("t1_tries", tries_left, 3);
    tick(3);
    check_eq("t1_done_early", done, 0);
    tick();
    check_eq("t1_done", done, 1);
    check_eq("t1_fail", fail, 0);
    start = 1'b0;
    tick();
    check_eq("t1_done_clr", done, 0);

    // hold interrupted by one off-target cycle restarts the count
    start = 1'b1;
    tick();
    tick(2);
    pickY = 10'd210;
    tick();
    check_eq("t2_slot6", slot, 6);
    check_eq("t2_no_done", done, 0);
    pickY = 10'd185;
    tick();
    tick(3);
    check_eq("t2_done_early", done, 0);
    tick();
    check_eq("t2_done", done, 1);
    check_eq("t2_tries", tries_left, 3);
    start = 1'b0;
    tick();

    // three opener edges off-target lead to fail
    pickY = 10'd100; start = 1'b1;
    tick();
    check_eq("t3_slot", slot, 2);
    openner = 1'b1; tick();
    check_eq("t3_tries2", tries_left, 2);
    check_eq("t3_fail0", fail, 0);
    openner = 1'b0; tick();
    check_eq("t3_tries_hold", tries_left, 2);
    openner = 1'b1; tick();
    check_eq("t3_tries1", tries_left, 1);
    openner = 1'b0; tick();
    openner = 1'b1; tick();
    check_eq("t3_tries0", tries_left, 0);
    check_eq("t3_fail", fail, 1);
    openner = 1'b0; tick();
    openner = 1'b1; tick();
    check_eq("t3_no_wrap", tries_left, 0);
    check_eq("t3_fail_hold", fail, 1);
    openner = 1'b0; start = 1'b0;
    tick();
    check_eq("t3_fail_clr", fail, 0);

    // close hint across modes and band edge
    mode = 2'd0; pickY = 10'd116; start = 1'b1;
    tick();
    check_eq("t4_slot3", slot, 3);
    check_eq("t4_close_easy", close, 1);
    mode = 2'd1; tick();
    check_eq("t4_close_med2", close, 0);
    mode = 2'd2; pickY = 10'd144; tick();
    check_eq("t4_slot4", slot, 4);
    check_eq("t4_close_hard", close, 0);
    mode = 2'd1; tick();
    check_eq("t4_close_med1", close, 1);
    pickY = 10'd480; tick();
    check_eq("t4_valid_out", slot_valid, 0);
    check_eq("t4_slot_hold", slot, 4);
    check_eq("t4_close_out", close, 0);
    start = 1'b0; tick();

    // no wrap-around: slot 15 is not near target 0; band edges
    rand_in = 4'd0; mode = 2'd0; pickY = 10'd479; start = 1'b1;
    tick();
    check_eq("t5_target0", target, 0);
    check_eq("t5_slot15", slot, 15);
    check_eq("t5_valid_top", slot_valid, 1);
    check_eq("t5_close_wrap", close, 0);
    pickY = 10'd60; tick();
    check_eq("t5_slot1", slot, 1);
    check_eq("t5_close_near", close, 1);
    pickY = 10'd31; tick();
    check_eq("t5_valid_low", slot_valid, 0);
    check_eq("t5_slot_hold", slot, 1);
    start = 1'b0; tick();

    // X limit boundary
    rand_in = 4'd5; mode = 2'd2; pickY = 10'd185; pickLRx = 10'd501; start = 1'b1;
    tick();
    tick(6);
    check_eq("t6_no_done_501", done, 0);
    pickLRx = 10'd500;
    tick(3);
    check_eq("t6_done_early", done, 0);
    tick();
    check_eq("t6_done_500", done, 1);
    start = 1'b0; tick();

    // async reset mid-hold, then fresh start on release
    start = 1'b1;
    tick(3);
    Reset_n = 1'b0;
    #1;
    check_eq("t7_slot", slot, 0);
    check_eq("t7_valid", slot_valid, 0);
    check_eq("t7_target", target, 0);
    check_eq("t7_tries", tries_left, 0);
    check_eq("t7_done", done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check_eq("t7_restart_target", target, 5);
    check_eq("t7_restart_tries", tries_left, 3);
    tick(4);
    check_eq("t7_restart_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
